regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32×64 register file (X31 hardwired zero) between two producers: the pipeline writeback stage (requester 0) and a multi-cycle execution unit (requester 1). Each requester has a small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs, one write per cycle, into registered RegWrite/WriteRegister/WriteData outputs that connect directly to the register file.

---
 rtl/regfile_write_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register-file write port between two producers
//
// regarb_fifo: one requester's write queue.
//   clk, reset         clock, asynchronous active-high reset
//   inValid/inReady    enqueue handshake; inReady = !full (count-based only)
//   inReg/inData       destination register / data; X31 entries are accepted but dropped
//   pop                dequeue the head when non-empty
//   notEmpty           queue holds at least one entry
//   headReg/headData   head entry
//   probeReg1/2, probeHit1/2   (REGARB_HAZARD_EN only) any live entry targets probeRegN
//
// regfile_write_arbiter: top level.
//   clk, reset                   clock, asynchronous active-high reset
//   req0_valid/ready/reg/data    writeback-stage requester
//   req1_valid/ready/reg/data    multi-cycle execution unit requester
//   RegWrite, WriteRegister, WriteData   registered register-file write port
//   busy                         any queue non-empty or a write on the port
//   ReadRegister1/2, hazard1/2   (REGARB_HAZARD_EN only) pending-write detection for reads
//
// Optional feature macro: REGARB_HAZARD_EN.

module regarb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [4:0]  inReg,
    input  logic [63:0] inData,
    input  logic        pop,
    output logic        notEmpty,
    output logic [4:0]  headReg,
    output logic [63:0] headData
`ifdef REGARB_HAZARD_EN
    ,
    input  logic [4:0]  probeReg1,
    input  logic [4:0]  probeReg2,
    output logic        probeHit1,
    output logic        probeHit2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    regMem  [DEPTH];
    logic [63:0]   dataMem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          full;
    logic          accept;
    logic          push;
    logic          doPop;

    // Readiness looks only at the stored count, never at pop, so there is no
    // path from the arbiter's grant back to the requester handshake.
    assign full     = (count == CW'(DEPTH));
    assign inReady  = !full;
    assign notEmpty = (count != '0);
    assign accept   = inValid && inReady;
    // Writes to X31 complete the handshake but are never stored.
    assign push     = accept && (inReg != 5'd31);
    assign doPop    = pop && notEmpty;
    assign headReg  = regMem[rdPtr];
    assign headData = dataMem[rdPtr];

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            regMem[wrPtr]  <= inReg;
            dataMem[wrPtr] <= inData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef REGARB_HAZARD_EN
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    // Slot i is live when its distance from the read pointer (mod DEPTH)
    // is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] offs;
        assign offs    = PW'(i) - rdPtr;
        assign live[i] = ({1'b0, offs} < count);
        assign hit1[i] = live[i] && (regMem[i] == probeReg1);
        assign hit2[i] = live[i] && (regMem[i] == probeReg2);
    end

    assign probeHit1 = |hit1;
    assign probeHit2 = |hit2;
`endif

endmodule

module regfile_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_reg,
    input  logic [63:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_reg,
    input  logic [63:0] req1_data,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    output logic        busy
`ifdef REGARB_HAZARD_EN
    ,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic        hazard1,
    output logic        hazard2
`endif
);

    logic        notEmpty0;
    logic        notEmpty1;
    logic [4:0]  head0Reg;
    logic [4:0]  head1Reg;
    logic [63:0] head0Data;
    logic [63:0] head1Data;
    logic        pop0;
    logic        pop1;
    logic        grantValid;
    logic        grantSel;
    logic        lastGrant;

`ifdef REGARB_HAZARD_EN
    logic q0Hit1;
    logic q0Hit2;
    logic q1Hit1;
    logic q1Hit2;
`endif

    regarb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo0 (
        .clk      (clk),
        .reset    (reset),
        .inValid  (req0_valid),
        .inReady  (req0_ready),
        .inReg    (req0_reg),
        .inData   (req0_data),
        .pop      (pop0),
        .notEmpty (notEmpty0),
        .headReg  (head0Reg),
        .headData (head0Data)
`ifdef REGARB_HAZARD_EN
        ,
        .probeReg1(ReadRegister1),
        .probeReg2(ReadRegister2),
        .probeHit1(q0Hit1),
        .probeHit2(q0Hit2)
`endif
    );

    regarb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo1 (
        .clk      (clk),
        .reset    (reset),
        .inValid  (req1_valid),
        .inReady  (req1_ready),
        .inReg    (req1_reg),
        .inData   (req1_data),
        .pop      (pop1),
        .notEmpty (notEmpty1),
        .headReg  (head1Reg),
        .headData (head1Data)
`ifdef REGARB_HAZARD_EN
        ,
        .probeReg1(ReadRegister1),
        .probeReg2(ReadRegister2),
        .probeHit1(q1Hit1),
        .probeHit2(q1Hit2)
`endif
    );

    // grantSel: 0 selects requester 0, 1 selects requester 1. With both
    // queues occupied the requester not served last wins; otherwise the
    // single occupied queue is served.
    assign grantValid = notEmpty0 || notEmpty1;
    assign grantSel   = (notEmpty0 && notEmpty1) ? !lastGrant : notEmpty1;
    assign pop0       = grantValid && !grantSel;
    assign pop1       = grantValid && grantSel;

    // lastGrant resets to 1 so requester 0 wins the first contended cycle.
    // WriteRegister/WriteData hold when idle; only RegWrite drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 64'd0;
            lastGrant     <= 1'b1;
        end else begin
            RegWrite <= grantValid;
            if (grantValid) begin
                WriteRegister <= grantSel ? head1Reg  : head0Reg;
                WriteData     <= grantSel ? head1Data : head0Data;
                lastGrant     <= grantSel;
            end
        end
    end

    assign busy = notEmpty0 || notEmpty1 || RegWrite;

`ifdef REGARB_HAZARD_EN
    // X31 reads never stall: the register is hardwired to zero.
    assign hazard1 = (ReadRegister1 != 5'd31) &&
                     (q0Hit1 || q1Hit1 || (RegWrite && (WriteRegister == ReadRegister1)));
    assign hazard2 = (ReadRegister2 != 5'd31) &&
                     (q0Hit2 || q1Hit2 || (RegWrite && (WriteRegister == ReadRegister2)));
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [4:0]  req0_reg = '0;
    logic [63:0] req0_data = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [4:0]  req1_reg = '0;
    logic [63:0] req1_data = '0;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic        busy;
`ifdef REGARB_HAZARD_EN
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = 5'd31;
    logic        hazard1;
    logic        hazard2;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_reg     (req0_reg),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_reg     (req1_reg),
        .req1_data    (req1_data),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .busy         (busy)
`ifdef REGARB_HAZARD_EN
        ,
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .hazard1      (hazard1),
        .hazard2      (hazard2)
`endif
    );

    int npass = 0;
    int ntotal = 0;

    // Reference model: one queue of {reg,data} per requester.
    logic [68:0] q0[$];
    logic [68:0] q1[$];
    logic        mLast;
    logic        mRegWrite;
    logic [4:0]  mWReg;
    logic [63:0] mWData;

    logic [72:0] got;
    logic [72:0] exp;

    // Register file fed by the write port.
    logic [63:0] rf [32];
    always @(posedge clk) begin
        if (RegWrite && WriteRegister != 5'd31) rf[WriteRegister] <= WriteData;
    end

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mLast = 1'b1;
        mRegWrite = 1'b0;
        mWReg = 5'd0;
        mWData = 64'd0;
    endtask

    function automatic logic [72:0] m_vec();
        return {mRegWrite, mWReg, mWData,
                (q0.size() > 0 || q1.size() > 0 || mRegWrite),
                (q0.size() < DEPTH), (q1.size() < DEPTH)};
    endfunction

    function automatic logic [72:0] dut_vec();
        return {RegWrite, WriteRegister, WriteData, busy, req0_ready, req1_ready};
    endfunction

`ifdef REGARB_HAZARD_EN
    function automatic logic m_hazard(input logic [4:0] rr);
        if (rr == 5'd31) return 1'b0;
        if (mRegWrite && mWReg == rr) return 1'b1;
        foreach (q0[i]) if (q0[i][68:64] == rr) return 1'b1;
        foreach (q1[i]) if (q1[i][68:64] == rr) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Drive one cycle of stimulus, advance the model across the edge and
    // return 1 time unit after the edge.
    task automatic cycle(input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [63:0] d1);
        logic a0;
        logic a1;
        logic [68:0] head;
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        a0 = v0 && (q0.size() < DEPTH);
        a1 = v1 && (q1.size() < DEPTH);
        @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && (q1.size() == 0 || mLast == 1'b1)) begin
                head = q0.pop_front();
                mLast = 1'b0;
            end else begin
                head = q1.pop_front();
                mLast = 1'b1;
            end
            mRegWrite = 1'b1;
            mWReg = head[68:64];
            mWData = head[63:0];
        end else begin
            mRegWrite = 1'b0;
        end
        if (a0 && r0 != 5'd31) q0.push_back({r0, d0});
        if (a1 && r1 != 5'd31) q1.push_back({r1, d1});
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        got = dut_vec();
        exp = {1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1};
        ntotal++;
        if (got !== exp) $display("FAIL reset_during: got %h expected %h", got, exp);
        else npass++;
        reset = 1'b0;
        idle();
        got = dut_vec();
        ntotal++;
        if (got !== exp) $display("FAIL reset_after: got %h expected %h", got, exp);
        else npass++;
    endtask

    task automatic test_single();
        do_reset();
        cycle(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0);
        ntotal++;
        if (RegWrite !== 1'b0) $display("FAIL single_edgeE_regwrite: got %b expected 0", RegWrite);
        else npass++;
        idle();
        got = {RegWrite, WriteRegister, WriteData, 3'b000};
        exp = {1'b1, 5'd5, 64'hDEAD, 3'b000};
        ntotal++;
        if (got !== exp) $display("FAIL single_write: got %h expected %h", got, exp);
        else npass++;
        idle();
        ntotal++;
        if (RegWrite !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_one_cycle: got regwrite %b busy %b expected 0 0", RegWrite, busy);
        else npass++;
        ntotal++;
        if (rf[5] !== 64'hDEAD) $display("FAIL single_readback: got %h expected %h", rf[5], 64'hDEAD);
        else npass++;
    endtask

    task automatic test_contention();
        logic [68:0] expw [4];
        expw[0] = {5'd3, 64'hA1};
        expw[1] = {5'd4, 64'hB1};
        expw[2] = {5'd6, 64'hA2};
        expw[3] = {5'd7, 64'hB2};
        do_reset();
        cycle(1'b1, 5'd3, 64'hA1, 1'b1, 5'd4, 64'hB1);
        cycle(1'b1, 5'd6, 64'hA2, 1'b1, 5'd7, 64'hB2);
        for (int i = 0; i < 4; i++) begin
            ntotal++;
            if (RegWrite !== 1'b1 || {WriteRegister, WriteData} !== expw[i])
                $display("FAIL contention_order%0d: got %b %h expected 1 %h", i, RegWrite,
                         {WriteRegister, WriteData}, expw[i]);
            else npass++;
            idle();
        end
        ntotal++;
        if (RegWrite !== 1'b0 || busy !== 1'b0)
            $display("FAIL contention_drained: got regwrite %b busy %b expected 0 0", RegWrite, busy);
        else npass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] sent0 [$];
        logic [63:0] seen0 [$];
        int sent;
        int cyc;
        int bad;
        logic sawFull;
        logic done;
        logic v0;
        logic acc;
        logic [63:0] d0;
        sent = 0; cyc = 0; bad = 0; sawFull = 1'b0; done = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) sent0.push_back({4'h0, 60'(i * 7 + 1)});
        while (!done && cyc < 300) begin
            v0 = (sent < 10);
            d0 = v0 ? sent0[sent] : 64'd0;
            acc = v0 && req0_ready;
            cycle(v0, 5'(sent + 1), d0, (cyc < 40), 5'd20, {4'h1, 60'(cyc)});
            if (acc) sent++;
            got = dut_vec();
            exp = m_vec();
            if (got !== exp) bad++;
            if (!req0_ready) sawFull = 1'b1;
            if (RegWrite && WriteData[63:60] == 4'h0) seen0.push_back(WriteData);
            done = (sent == 10) && (cyc >= 40) && q0.size() == 0 && q1.size() == 0 && !mRegWrite;
            cyc++;
        end
        ntotal++;
        if (!done) $display("FAIL backpressure_timeout: got %0d cycles expected drain", cyc);
        else npass++;
        ntotal++;
        if (bad != 0) $display("FAIL backpressure_model: got %0d mismatching cycles expected 0", bad);
        else npass++;
        ntotal++;
        if (sawFull !== 1'b1) $display("FAIL backpressure_ready_drop: got %b expected 1", sawFull);
        else npass++;
        bad = 0;
        foreach (seen0[i]) if (i >= 10 || seen0[i] !== sent0[i]) bad++;
        ntotal++;
        if (seen0.size() != 10 || bad != 0)
            $display("FAIL backpressure_order: got %0d writes %0d wrong expected 10 0", seen0.size(), bad);
        else npass++;
    endtask

    task automatic test_x31();
        int nw;
        logic [68:0] lastw;
        nw = 0;
        lastw = '0;
        do_reset();
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hA0);
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 64'h7);
        for (int i = 0; i < 5; i++) begin
            if (RegWrite) begin
                nw++;
                lastw = {WriteRegister, WriteData};
            end
            idle();
        end
        ntotal++;
        if (nw != 1) $display("FAIL x31_count: got %0d writes expected 1", nw);
        else npass++;
        ntotal++;
        if (lastw !== {5'd2, 64'h7}) $display("FAIL x31_write: got %h expected %h", lastw, {5'd2, 64'h7});
        else npass++;
    endtask

    task automatic test_reset_mid();
        int nw;
        nw = 0;
        do_reset();
        cycle(1'b1, 5'd11, 64'h11, 1'b0, 5'd0, 64'd0);
        cycle(1'b1, 5'd12, 64'h12, 1'b0, 5'd0, 64'd0);
        cycle(1'b1, 5'd13, 64'h13, 1'b0, 5'd0, 64'd0);
        req0_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        got = dut_vec();
        exp = {1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1};
        ntotal++;
        if (got !== exp) $display("FAIL reset_mid_async: got %h expected %h", got, exp);
        else npass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (RegWrite) nw++;
        end
        ntotal++;
        if (nw != 0 || busy !== 1'b0)
            $display("FAIL reset_mid_nowrite: got %0d writes busy %b expected 0 0", nw, busy);
        else npass++;
    endtask

`ifdef REGARB_HAZARD_EN
    task automatic test_hazard();
        logic [2:0] seq;
        do_reset();
        ReadRegister1 = 5'd9;
        ReadRegister2 = 5'd31;
        #1;
        ntotal++;
        if (hazard1 !== 1'b0) $display("FAIL hazard_idle: got %b expected 0", hazard1);
        else npass++;
        cycle(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0);
        seq[2] = hazard1;
        idle();
        seq[1] = hazard1;
        idle();
        seq[0] = hazard1;
        ntotal++;
        if (seq !== 3'b110) $display("FAIL hazard_x9_seq: got %b expected 110", seq);
        else npass++;
        ntotal++;
        if (hazard2 !== 1'b0) $display("FAIL hazard_x31: got %b expected 0", hazard2);
        else npass++;
    endtask
`endif

    task automatic test_random();
        int bad;
        int hbad;
        logic [4:0] r0;
        logic [4:0] r1;
        bad = 0;
        hbad = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r0 = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 32);
            r1 = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom % 32);
            cycle(($urandom % 3) != 0, r0, {$urandom, $urandom},
                  ($urandom % 3) != 0, r1, {$urandom, $urandom});
`ifdef REGARB_HAZARD_EN
            ReadRegister1 = 5'($urandom % 32);
            ReadRegister2 = ($urandom % 4 == 0) ? 5'd31 : 5'($urandom % 32);
            #1;
            if (hazard1 !== m_hazard(ReadRegister1) || hazard2 !== m_hazard(ReadRegister2)) hbad++;
`endif
            got = dut_vec();
            exp = m_vec();
            if (got !== exp) begin
                bad++;
                if (bad <= 3) $display("FAIL random_cycle%0d: got %h expected %h", c, got, exp);
            end
            if ($urandom % 64 == 0) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                reset = 1'b1;
                model_reset();
                #1;
                got = dut_vec();
                exp = m_vec();
                if (got !== exp) bad++;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        end
        ntotal++;
        if (bad != 0) $display("FAIL random_model: got %0d mismatches expected 0", bad);
        else npass++;
        ntotal++;
        if (hbad != 0) $display("FAIL random_hazard: got %0d mismatches expected 0", hbad);
        else npass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_x31();
        test_reset_mid();
`ifdef REGARB_HAZARD_EN
        test_hazard();
`endif
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
